pipelined_channel_mux: RTL and testbench
========================================

// Module: pipelined_channel_mux
// PURPOSE
//   Parametrised, registered N:1 channel multiplexer with valid/ready flow control.
//   Generalises the 4:1 single-bit structural mux to CHANNELS inputs of WIDTH bits.
//   Two select modes: ADDRESSED (external address) or ROUND_ROBIN (fair internal arbitration).
//   Sits between multiple producer channels and one downstream consumer; adds one register stage.
// PARAMETERS
//   WIDTH     8                    data bits per channel
//   CHANNELS  4                    number of input channels (>=2)
//   SEL_W     $clog2(CHANNELS)     width of address/out_channel (derived, do not override)
// PORTS
//   clk          input   1                 single clock, all state on rising edge
//   rst_n        input   1                 asynchronous, active-low reset
//   mode         input   1                 0 = ADDRESSED, 1 = ROUND_ROBIN
//   address      input   SEL_W             channel select in ADDRESSED mode
//   in_data      input   CHANNELS*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid     input   CHANNELS          per-channel valid
//   in_ready     output  CHANNELS          per-channel ready (one-hot or zero)
//   out_data     output  WIDTH             registered selected data
//   out_channel  output  SEL_W             registered index of channel that supplied out_data
//   out_valid    output  1                 out_data/out_channel hold a word
//   out_ready    input   1                 consumer accepts word when out_valid && out_ready
// BEHAVIOUR
//   Reset (rst_n=0, async assert, sync release): out_valid=0, out_data=0, out_channel=0,
//     rr_ptr=CHANNELS-1 (so channel 0 has first priority); in_ready=0 while in reset.
//   Output register states: EMPTY (out_valid=0) / FULL (out_valid=1).
//     load_en = !out_valid || out_ready   (pass-through when draining same cycle).
//     EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on out_ready with grant
//     or when out_ready=0 (contents held stable, no change to out_data/out_channel).
//   Grant selection (combinational, from current inputs):
//     ADDRESSED: candidate = address; if address >= CHANNELS no candidate (in_ready all 0).
//     ROUND_ROBIN: candidate = first k with in_valid[k], searching rr_ptr+1, rr_ptr+2, ... wrapping
//       modulo CHANNELS; no candidate if in_valid==0.
//     in_ready[candidate] = load_en; all other in_ready bits 0. in_ready never depends on in_valid
//       in ADDRESSED mode; in ROUND_ROBIN it is asserted only on the chosen valid channel.
//   Transfer: grant = in_valid[c] && in_ready[c]. On grant, next edge: out_data <= channel c data,
//     out_channel <= c, out_valid <= 1. Latency input->output exactly 1 cycle.
//   rr_ptr updates to c only on a grant in ROUND_ROBIN mode; unchanged in ADDRESSED mode.
//   mode/address may change any cycle; affect only the current cycle's grant, never a held word.
//   Throughput: out_ready held 1 and candidate valid -> one word per cycle, no bubbles.
//   Reset mid-operation: held word is discarded, out_valid drops immediately (async).
// TESTING
//   1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0; release, mode=0,
//      address=2, in_data ch2=8'hA5 -> next cycle out_data=A5, out_channel=2, out_valid=1.
//   2. Addressed sweep: address 0..3, ch k data=8'h10+k, out_ready=1 -> outputs 10,11,12,13 on
//      consecutive cycles, one cycle after each select; in_ready one-hot on addressed channel.
//   3. Backpressure: FULL with 8'h3C, out_ready=0 for 5 cycles while in_data changes -> out_data
//      stays 3C, in_ready=0; out_ready=1 -> next word loads same edge as 3C drains.
//   4. Round-robin fairness: mode=1, all 4 in_valid=1, out_ready=1 -> out_channel 0,1,2,3,0,1...;
//      then in_valid=4'b1010 -> grants alternate 1,3,1,3.
//   5. Wrap/skip: rr_ptr=3, in_valid=4'b0100 -> grant ch2; in_valid=0 -> out_valid drops after drain.
//   6. Out-of-range/async reset: CHANNELS=3 build, address=3 -> in_ready=0, no load; assert rst_n
//      mid-stream with FULL -> out_valid=0 without waiting for clk edge.

Source files
------------

// File: rtl/pipelined_channel_mux_if.sv
// ---------------------------------------------------------------------------
// pipelined_channel_mux_if
//   Bundle of the producer-side and consumer-side signals of
//   pipelined_channel_mux. Clock and reset are plain module ports.
//
//   mode         0 = ADDRESSED, 1 = ROUND_ROBIN
//   address      channel select used in ADDRESSED mode
//   in_data      channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (one-hot or zero)
//   out_data     registered selected word
//   out_channel  registered index of the channel that supplied out_data
//   out_valid    out_data/out_channel hold a word
//   out_ready    consumer accepts the word when out_valid && out_ready
//
//   modport slave  : the mux itself
//   modport master : whatever drives the mux (producers + consumer)
// ---------------------------------------------------------------------------
interface pipelined_channel_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic                      mode;
    logic [SEL_W-1:0]          address;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_channel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, address, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );

    modport slave (
        input  mode, address, in_data, in_valid, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );
endinterface

// File: rtl/pipelined_channel_mux.sv
// ---------------------------------------------------------------------------
// pipelined_channel_mux
//   Registered CHANNELS:1 multiplexer with valid/ready flow control. The
//   winning channel is picked either by an external address (ADDRESSED) or by
//   a fair round-robin search starting after the last granted channel
//   (ROUND_ROBIN). One output register stage; input-to-output latency is one
//   cycle and a full register can drain and reload on the same edge.
//
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous assert, synchronous release, active low
//   bus    : pipelined_channel_mux_if.slave (see the interface for signals)
// ---------------------------------------------------------------------------
module pipelined_channel_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_channel_mux_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_channel_q, out_channel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_idx;
    logic             cand_vld;
    logic             load_en;
    logic             grant;

    // The register may accept a word when empty or when its word leaves
    // this cycle.
    assign load_en = (state_q == EMPTY) || bus.out_ready;

    // Candidate selection. ADDRESSED ignores in_valid entirely, so a producer
    // can see ready before it raises valid. ROUND_ROBIN looks at rr_ptr+1,
    // rr_ptr+2, ... and takes the first valid channel.
    // NOTE: every signal assigned in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin : candidate_select
        cand_vld = 1'b0;
        cand     = '0;
        rr_idx   = '0;
        if (!bus.mode) begin
            if (int'(bus.address) < CHANNELS) begin
                cand_vld = 1'b1;
                cand     = bus.address;
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                rr_idx = SEL_W'((int'(rr_ptr_q) + i) % CHANNELS);
                if (!cand_vld && bus.in_valid[rr_idx]) begin
                    cand_vld = 1'b1;
                    cand     = rr_idx;
                end
            end
        end
    end

    // Ready is held low during reset so no producer believes a word was taken.
    assign bus.in_ready = (rst_n && cand_vld && load_en) ? (CHANNELS'(1) << cand) : '0;
    assign grant        = |(bus.in_ready & bus.in_valid);

    always_comb begin : next_state
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant) begin
            state_d       = FULL;
            out_data_d    = bus.in_data[int'(cand)*WIDTH +: WIDTH];
            out_channel_d = cand;
            if (bus.mode) begin
                rr_ptr_d = cand;
            end
        end else if (bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    // NOTE: all state, including the data register, is reset; out_data must
    // read zero while in reset, and rr_ptr starts at CHANNELS-1 so channel 0
    // has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            out_data_q    <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.out_valid   = (state_q == FULL);
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;

endmodule

// File: tb/tb_pipelined_channel_mux.sv
// ---------------------------------------------------------------------------
// tb_pipelined_channel_mux
//   Self-checking bench for pipelined_channel_mux. A 4-channel instance is
//   driven through directed sequences; every granted word is pushed to a
//   scoreboard queue when driven and popped when the DUT presents it with
//   out_ready high. A 3-channel instance covers out-of-range addressing and
//   round-robin wrap on a non-power-of-two channel count.
// ---------------------------------------------------------------------------
module tb_pipelined_channel_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_channel_mux_if #(.WIDTH(8), .CHANNELS(4)) a ();
    pipelined_channel_mux_if #(.WIDTH(8), .CHANNELS(3)) b ();

    pipelined_channel_mux #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    pipelined_channel_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } item_t;

    item_t sb_q[$];
    item_t exp_item;
    int    n_total = 0;
    int    n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int data);
        sb_q.push_back({2'(ch), 8'(data)});
    endtask

    task automatic set_ch(input int k, input int v);
        a.in_data[k*8 +: 8] = 8'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard consumer for the 4-channel instance.
    always @(negedge clk) begin
        if (rst_n && a.out_valid && a.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_depth_on_output", sb_q.size(), 1);
            end else begin
                exp_item = sb_q.pop_front();
                check("out_data", a.out_data, exp_item.data);
                check("out_channel", a.out_channel, exp_item.ch);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d", n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        a.mode     = 1'b0;
        a.address  = '0;
        a.in_valid = '1;
        a.in_data  = '0;
        a.out_ready = 1'b1;
        b.mode     = 1'b0;
        b.address  = '0;
        b.in_valid = '0;
        b.in_data  = '0;
        b.out_ready = 1'b1;

        // 1. Reset state, then first word through.
        repeat (3) tick();
        check("rst_out_valid", a.out_valid, 0);
        check("rst_out_data", a.out_data, 0);
        check("rst_out_channel", a.out_channel, 0);
        check("rst_in_ready", a.in_ready, 0);

        a.address = 2'd2;
        set_ch(2, 8'hA5);
        rst_n = 1'b1;
        push(2, 8'hA5);
        settle();
        check("t1_in_ready", a.in_ready, 32'b0100);
        tick();
        check("t1_out_valid", a.out_valid, 1);

        // 2. Addressed sweep, one word per cycle.
        for (int k = 0; k < 4; k++) set_ch(k, 8'h10 + k);
        for (int k = 0; k < 4; k++) begin
            a.address = 2'(k);
            push(k, 8'h10 + k);
            settle();
            check("t2_in_ready", a.in_ready, 32'(1) << k);
            tick();
        end

        // 3. Backpressure: hold 3C while inputs move, then drain and reload.
        a.address = 2'd1;
        set_ch(1, 8'h3C);
        push(1, 8'h3C);
        tick();
        a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ch(1, 8'h40 + i);
            settle();
            check("t3_in_ready_stalled", a.in_ready, 0);
            check("t3_hold_data", a.out_data, 8'h3C);
            check("t3_hold_valid", a.out_valid, 1);
            tick();
        end
        a.out_ready = 1'b1;
        set_ch(1, 8'h77);
        push(1, 8'h77);
        settle();
        check("t3_in_ready_drain", a.in_ready, 32'b0010);
        tick();
        a.in_valid = '0;
        settle();
        check("t3_in_ready_no_valid", a.in_ready, 32'b0010);
        tick();
        check("t3_drained", a.out_valid, 0);

        // 4. Round-robin fairness, then alternating subset.
        a.mode = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 8'h20 + k);
        a.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(i % 4, 8'h20 + (i % 4));
            settle();
            check("t4_rr_all", a.in_ready, 32'(1) << (i % 4));
            tick();
        end
        a.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            push((i % 2 == 0) ? 1 : 3, (i % 2 == 0) ? 8'h21 : 8'h23);
            settle();
            check("t4_rr_alt", a.in_ready, (i % 2 == 0) ? 32'b0010 : 32'b1000);
            tick();
        end

        // 5. Wrap/skip from rr_ptr=3, then idle drain.
        a.in_valid = 4'b0100;
        push(2, 8'h22);
        settle();
        check("t5_wrap_skip", a.in_ready, 32'b0100);
        tick();
        a.in_valid = '0;
        settle();
        check("t5_rr_none", a.in_ready, 0);
        tick();
        check("t5_out_valid_drop", a.out_valid, 0);

        // 6a. Three-channel build: out-of-range address and round-robin wrap.
        b.in_valid = 3'b111;
        b.in_data  = {8'h33, 8'h22, 8'h11};
        b.address  = 2'd3;
        settle();
        check("t6_oor_in_ready", b.in_ready, 0);
        tick();
        check("t6_oor_no_load", b.out_valid, 0);
        b.address = 2'd2;
        settle();
        check("t6_addr2_in_ready", b.in_ready, 32'b100);
        tick();
        check("t6_addr2_data", b.out_data, 8'h33);
        check("t6_addr2_channel", b.out_channel, 2);
        check("t6_addr2_valid", b.out_valid, 1);
        b.mode     = 1'b1;
        b.in_valid = 3'b110;
        settle();
        check("t6_rr_first", b.in_ready, 32'b010);
        tick();
        check("t6_rr_first_ch", b.out_channel, 1);
        settle();
        check("t6_rr_second", b.in_ready, 32'b100);
        tick();
        check("t6_rr_second_ch", b.out_channel, 2);
        settle();
        check("t6_rr_wrap", b.in_ready, 32'b010);

        // 6b. Asynchronous reset while a word is held.
        a.mode      = 1'b0;
        a.address   = 2'd0;
        a.in_valid  = 4'b0001;
        set_ch(0, 8'h5A);
        a.out_ready = 1'b0;
        tick();
        check("t6_held_valid", a.out_valid, 1);
        check("t6_held_data", a.out_data, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", a.out_valid, 0);
        check("t6_async_out_data", a.out_data, 0);
        check("t6_async_in_ready", a.in_ready, 0);
        check("t6_async_b_valid", b.out_valid, 0);
        tick();
        a.in_valid = '0;
        b.in_valid = '0;
        rst_n = 1'b1;
        tick();
        check("t6_post_reset_empty", a.out_valid, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
